ewa_vec_pipe: RTL and testbench



---
 rtl/ewa_pkg.sv | 29 ++
 rtl/ewa_lane.sv | 98 +++++++++
 rtl/ewa_vec_pipe.sv | 174 +++++++++++++++++
 tb/tb_ewa_vec_pipe.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ewa_pkg.sv
// Shared types and constants for the element-wise vector ALU pipeline.
package ewa_pkg;

   // Lane operation encoding, matches the 2-bit in_op field.
   typedef enum logic [1:0] {
      EWA_ADD = 2'b00,
      EWA_SUB = 2'b01,
      EWA_MAX = 2'b10,
      EWA_MIN = 2'b11
   } ewa_op_e;

   // Deepest pipeline the top is meant to be configured with.
   localparam int EWA_MAX_STAGES = 4;

   // Width of the optional saturation event counter.
   localparam int EWA_SATCNT_W = 32;

   // Increment that sticks at all-ones instead of wrapping to zero.
   function automatic logic [EWA_SATCNT_W-1:0] ewa_sat_inc(input logic [EWA_SATCNT_W-1:0] cnt);
      logic [EWA_SATCNT_W-1:0] nxt;
      if (cnt == {EWA_SATCNT_W{1'b1}}) begin
         nxt = cnt;
      end else begin
         nxt = cnt + {{(EWA_SATCNT_W-1){1'b0}}, 1'b1};
      end
      return nxt;
   endfunction

endpackage

// File: rtl/ewa_lane.sv
// Single-lane combinational ALU: ADD/SUB/MAX/MIN at W+1 bits, then either
// clamp to the W-bit range (flagging sat) or keep the low W bits.
module ewa_lane
   import ewa_pkg::*;
#(
   parameter int W         = 16,
   parameter int SIGNED_IO = 1,
   parameter int SATURATE  = 1
) (
   input  ewa_op_e        op_i,
   input  logic [W-1:0]   a_i,
   input  logic [W-1:0]   b_i,
   output logic [W-1:0]   y_o,
   output logic           sat_o
);

   logic [W:0]   a_x_s;
   logic [W:0]   b_x_s;
   logic [W:0]   res_s;
   logic [W-1:0] clamp_s;
   logic         gt_s;
   logic         arith_s;
   logic         ovf_s;

   // Extend operands, compute the raw result and decide on clamping.
   always_comb begin
      a_x_s   = '0;
      b_x_s   = '0;
      res_s   = '0;
      clamp_s = '0;
      gt_s    = 1'b0;
      arith_s = 1'b0;
      ovf_s   = 1'b0;
      y_o     = '0;
      sat_o   = 1'b0;

      // Sign- or zero-extend so one signed W+1 comparison serves both modes.
      if (SIGNED_IO != 32'sd0) begin
         a_x_s = {a_i[W-1], a_i};
         b_x_s = {b_i[W-1], b_i};
      end else begin
         a_x_s = {1'b0, a_i};
         b_x_s = {1'b0, b_i};
      end

      gt_s = ($signed(a_x_s) > $signed(b_x_s));

      case (op_i)
         EWA_ADD: begin
            res_s   = a_x_s + b_x_s;
            arith_s = 1'b1;
         end
         EWA_SUB: begin
            res_s   = a_x_s - b_x_s;
            arith_s = 1'b1;
         end
         EWA_MAX: begin
            res_s   = gt_s ? a_x_s : b_x_s;
            arith_s = 1'b0;
         end
         EWA_MIN: begin
            res_s   = gt_s ? b_x_s : a_x_s;
            arith_s = 1'b0;
         end
         default: begin
            res_s   = '0;
            arith_s = 1'b0;
         end
      endcase

      // Signed: overflow when the two top bits disagree; the top bit gives direction.
      // Unsigned: bit W is carry for ADD and borrow for SUB.
      if (SIGNED_IO != 32'sd0) begin
         ovf_s = res_s[W] ^ res_s[W-1];
         if (res_s[W]) begin
            clamp_s = {1'b1, {(W-1){1'b0}}};
         end else begin
            clamp_s = {1'b0, {(W-1){1'b1}}};
         end
      end else begin
         ovf_s = res_s[W];
         if (op_i == EWA_ADD) begin
            clamp_s = {W{1'b1}};
         end else begin
            clamp_s = {W{1'b0}};
         end
      end

      if (arith_s && ovf_s && (SATURATE != 32'sd0)) begin
         y_o   = clamp_s;
         sat_o = 1'b1;
      end else begin
         y_o   = res_s[W-1:0];
         sat_o = 1'b0;
      end
   end

endmodule

// File: rtl/ewa_vec_pipe.sv
// Element-wise vector ALU over TILE_SIZE lanes with a STAGES-deep
// valid/ready pipeline (bubble collapsing, combinational ready chain).
// Stage 1 holds the computed lanes; later stages are pure delay.
// Optional feature macro: EWA_SAT_CNT_EN adds sat_clr / sat_count, a
// sticky-at-max counter of output transfers that carried any sat flag.
module ewa_vec_pipe
   import ewa_pkg::*;
#(
   parameter int TILE_SIZE = 4,
   parameter int W         = 16,
   parameter int SIGNED_IO = 1,
   parameter int SATURATE  = 1,
   parameter int STAGES    = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [1:0]              in_op,
   input  logic                    in_last,
   input  logic [W*TILE_SIZE-1:0]  a_vec,
   input  logic [W*TILE_SIZE-1:0]  b_vec,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [W*TILE_SIZE-1:0]  y_vec,
   output logic                    out_last,
   output logic [TILE_SIZE-1:0]    out_sat,
   output logic                    busy
`ifdef EWA_SAT_CNT_EN
   ,
   input  logic                    sat_clr,
   output logic [EWA_SATCNT_W-1:0] sat_count
`endif
);

   localparam int DW = W * TILE_SIZE;

   ewa_op_e               op_s;
   logic [DW-1:0]         lane_y_s;
   logic [TILE_SIZE-1:0]  lane_sat_s;

   logic [STAGES-1:0]     valid_q;
   logic [STAGES-1:0]     valid_d;
   logic [STAGES-1:0]     last_q;
   logic [STAGES-1:0]     last_d;
   logic [DW-1:0]         data_q [STAGES];
   logic [DW-1:0]         data_d [STAGES];
   logic [TILE_SIZE-1:0]  sat_q  [STAGES];
   logic [TILE_SIZE-1:0]  sat_d  [STAGES];

   logic [STAGES-1:0]     ready_s;
   logic                  chain_s;

   assign op_s = ewa_op_e'(in_op);

   for (genvar l = 0; l < TILE_SIZE; l++) begin : g_lane
      ewa_lane #(
         .W         (W),
         .SIGNED_IO (SIGNED_IO),
         .SATURATE  (SATURATE)
      ) u_lane (
         .op_i  (op_s),
         .a_i   (a_vec[l*W +: W]),
         .b_i   (b_vec[l*W +: W]),
         .y_o   (lane_y_s[l*W +: W]),
         .sat_o (lane_sat_s[l])
      );
   end

   // Ready chain: a stage can take data if it, or any stage after it, is empty, or out_ready.
   always_comb begin
      ready_s = '0;
      chain_s = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         chain_s    = chain_s | ~valid_q[k];
         ready_s[k] = chain_s;
      end
   end

   // Stage next-state: a stage advances when ready, and only loads payload when upstream is valid.
   always_comb begin
      valid_d = valid_q;
      last_d  = last_q;
      data_d  = data_q;
      sat_d   = sat_q;

      if (ready_s[0]) begin
         valid_d[0] = in_valid;
         if (in_valid) begin
            data_d[0] = lane_y_s;
            last_d[0] = in_last;
            sat_d[0]  = lane_sat_s;
         end else begin
            data_d[0] = data_q[0];
            last_d[0] = last_q[0];
            sat_d[0]  = sat_q[0];
         end
      end else begin
         valid_d[0] = valid_q[0];
      end

      for (int k = 1; k < STAGES; k++) begin
         if (ready_s[k]) begin
            valid_d[k] = valid_q[k-1];
            if (valid_q[k-1]) begin
               data_d[k] = data_q[k-1];
               last_d[k] = last_q[k-1];
               sat_d[k]  = sat_q[k-1];
            end else begin
               data_d[k] = data_q[k];
               last_d[k] = last_q[k];
               sat_d[k]  = sat_q[k];
            end
         end else begin
            valid_d[k] = valid_q[k];
         end
      end
   end

   // Stage registers; reset empties the pipe and clears every payload.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         last_q  <= '0;
         for (int k = 0; k < STAGES; k++) begin
            data_q[k] <= '0;
            sat_q[k]  <= '0;
         end
      end else begin
         valid_q <= valid_d;
         last_q  <= last_d;
         for (int k = 0; k < STAGES; k++) begin
            data_q[k] <= data_d[k];
            sat_q[k]  <= sat_d[k];
         end
      end
   end

   assign in_ready  = ready_s[0];
   assign out_valid = valid_q[STAGES-1];
   assign y_vec     = data_q[STAGES-1];
   assign out_last  = last_q[STAGES-1];
   assign out_sat   = sat_q[STAGES-1];
   assign busy      = |valid_q;

`ifdef EWA_SAT_CNT_EN
   logic [EWA_SATCNT_W-1:0] sat_cnt_q;
   logic [EWA_SATCNT_W-1:0] sat_cnt_d;

   // Counter next-state: clear beats a same-cycle saturated output transfer.
   always_comb begin
      sat_cnt_d = sat_cnt_q;
      if (sat_clr) begin
         sat_cnt_d = '0;
      end else if (out_valid && out_ready && (|out_sat)) begin
         sat_cnt_d = ewa_sat_inc(sat_cnt_q);
      end else begin
         sat_cnt_d = sat_cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         sat_cnt_q <= '0;
      end else begin
         sat_cnt_q <= sat_cnt_d;
      end
   end

   assign sat_count = sat_cnt_q;
`endif

endmodule

// File: tb/tb_ewa_vec_pipe.sv
// Bench for ewa_vec_pipe: three STAGES=3 instances (signed+sat, unsigned+sat,
// signed+wrap) share one stimulus stream and are compared each cycle against
// a queue-based model (head visible once it is STAGES cycles old).
module tb_ewa_vec_pipe;

   localparam int STAGES = 3;
   localparam int NI     = 3;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [1:0]  in_op;
   logic        in_last;
   logic [63:0] a_vec;
   logic [63:0] b_vec;
   logic        out_ready;

   logic [NI-1:0] ir;
   logic [NI-1:0] ov;
   logic [NI-1:0] ol;
   logic [NI-1:0] bz;
   logic [63:0]   yw [NI];
   logic [3:0]    sw [NI];
`ifdef EWA_SAT_CNT_EN
   logic          sat_clr;
   logic [31:0]   scw  [NI];
   longint        sc_m [NI];
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int cur_lit = -1;
   int n_emit = 0;

   typedef struct {
      int               acc;
      logic             last;
      logic [2:0][63:0] y;
      logic [2:0][3:0]  s;
   } ent_t;
   ent_t q[$];

   bit sg_cfg [NI] = '{1'b1, 1'b0, 1'b1};
   bit st_cfg [NI] = '{1'b1, 1'b1, 1'b0};

   logic [1:0]  lit_op [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
   logic [63:0] lit_a  [4] = '{64'hFFFF_1234_8000_7FFF, 64'h7FFF_0005_0001_8000,
                               64'h7FFF_0003_8000_FFFF, 64'h7FFF_0003_8000_FFFF};
   logic [63:0] lit_b  [4] = '{64'h0002_0001_FFFF_0001, 64'hFFFF_0003_0002_0001,
                               64'h8000_0003_7FFF_0001, 64'h8000_0003_7FFF_0001};
   logic [63:0] lit_y  [4][NI] = '{
      '{64'h0001_1235_8000_7FFF, 64'hFFFF_1235_FFFF_8000, 64'h0001_1235_7FFF_8000},
      '{64'h7FFF_0002_FFFF_8000, 64'h0000_0002_0000_7FFF, 64'h8000_0002_FFFF_7FFF},
      '{64'h7FFF_0003_7FFF_0001, 64'h8000_0003_8000_FFFF, 64'h7FFF_0003_7FFF_0001},
      '{64'h8000_0003_8000_FFFF, 64'h7FFF_0003_7FFF_0001, 64'h8000_0003_8000_FFFF}};
   logic [3:0]  lit_s  [4][NI] = '{
      '{4'b0011, 4'b1010, 4'b0000},
      '{4'b1001, 4'b1010, 4'b0000},
      '{4'b0000, 4'b0000, 4'b0000},
      '{4'b0000, 4'b0000, 4'b0000}};

   for (genvar g = 0; g < NI; g++) begin : g_dut
      ewa_vec_pipe #(
         .TILE_SIZE (4),
         .W         (16),
         .SIGNED_IO ((g == 1) ? 0 : 1),
         .SATURATE  ((g == 2) ? 0 : 1),
         .STAGES    (STAGES)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid),
         .in_ready  (ir[g]),
         .in_op     (in_op),
         .in_last   (in_last),
         .a_vec     (a_vec),
         .b_vec     (b_vec),
         .out_valid (ov[g]),
         .out_ready (out_ready),
         .y_vec     (yw[g]),
         .out_last  (ol[g]),
         .out_sat   (sw[g]),
         .busy      (bz[g])
`ifdef EWA_SAT_CNT_EN
         ,
         .sat_clr   (sat_clr),
         .sat_count (scw[g])
`endif
      );
   end

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter used to age queued vectors.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", name, got, exp);
      end
   endtask

   // Reference lane: plain integer arithmetic against the numeric range.
   function automatic void lane_ref(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                    input bit sgn, input bit satur,
                                    output logic [15:0] y, output logic s);
      longint av, bv, r, lo, hi;
      if (sgn) begin
         av = longint'($signed(a)); bv = longint'($signed(b)); lo = -32768; hi = 32767;
      end else begin
         av = longint'(a); bv = longint'(b); lo = 0; hi = 65535;
      end
      case (op)
         2'd0:    r = av + bv;
         2'd1:    r = av - bv;
         2'd2:    r = (av > bv) ? av : bv;
         default: r = (av < bv) ? av : bv;
      endcase
      s = 1'b0;
      y = r[15:0];
      if ((op <= 2'd1) && ((r > hi) || (r < lo)) && satur) begin
         s = 1'b1;
         y = (r > hi) ? hi[15:0] : lo[15:0];
      end
   endfunction

   function automatic void vec_ref(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                                   input bit sgn, input bit satur,
                                   output logic [63:0] y, output logic [3:0] s);
      logic [15:0] yl;
      logic        sl;
      y = '0;
      s = '0;
      for (int i = 0; i < 4; i++) begin
         lane_ref(op, a[i*16 +: 16], b[i*16 +: 16], sgn, satur, yl, sl);
         y[i*16 +: 16] = yl;
         s[i] = sl;
      end
   endfunction

   function automatic logic [15:0] rnd_lane();
      case ($urandom_range(0, 5))
         0:       return 16'h0000;
         1:       return 16'h0001;
         2:       return 16'h7FFF;
         3:       return 16'h8000;
         4:       return 16'hFFFF;
         default: return 16'($urandom);
      endcase
   endfunction

   // Compare outputs against the model, then apply this cycle's transfers to it.
   always @(negedge clk) begin
      bit   exp_ov;
      bit   exp_ir;
      ent_t e;
      logic [63:0] ty;
      logic [3:0]  ts;
      if (rst) begin
         q.delete();
`ifdef EWA_SAT_CNT_EN
         for (int j = 0; j < NI; j++) sc_m[j] = 0;
`endif
      end else begin
         exp_ov = 1'b0;
         if (q.size() > 0) exp_ov = ((cyc - q[0].acc) >= STAGES);
         exp_ir = (q.size() < STAGES) || out_ready;
         for (int j = 0; j < NI; j++) begin
            chk($sformatf("d%0d_out_valid", j), 64'(ov[j]), 64'(exp_ov));
            chk($sformatf("d%0d_in_ready", j), 64'(ir[j]), 64'(exp_ir));
            chk($sformatf("d%0d_busy", j), 64'(bz[j]), 64'(q.size() > 0));
            if (exp_ov) begin
               chk($sformatf("d%0d_y_vec", j), yw[j], q[0].y[j]);
               chk($sformatf("d%0d_out_sat", j), 64'(sw[j]), 64'(q[0].s[j]));
               chk($sformatf("d%0d_out_last", j), 64'(ol[j]), 64'(q[0].last));
            end
`ifdef EWA_SAT_CNT_EN
            chk($sformatf("d%0d_sat_count", j), 64'(scw[j]), 64'(sc_m[j]));
            if (sat_clr) begin
               sc_m[j] = 0;
            end else if (exp_ov && out_ready && (q[0].s[j] != 4'd0) && (sc_m[j] < 64'hFFFF_FFFF)) begin
               sc_m[j] = sc_m[j] + 1;
            end
`endif
         end
         if (exp_ov && out_ready) begin
            void'(q.pop_front());
            n_emit++;
         end
         if (in_valid && exp_ir) begin
            e.acc  = cyc;
            e.last = in_last;
            for (int j = 0; j < NI; j++) begin
               vec_ref(in_op, a_vec, b_vec, sg_cfg[j], st_cfg[j], ty, ts);
               e.y[j] = ty;
               e.s[j] = ts;
               if (cur_lit >= 0) begin
                  chk($sformatf("model_lit%0d_d%0d_y", cur_lit, j), ty, lit_y[cur_lit][j]);
                  chk($sformatf("model_lit%0d_d%0d_sat", cur_lit, j), 64'(ts), 64'(lit_s[cur_lit][j]));
               end
            end
            q.push_back(e);
         end
      end
   end

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic last, input int lit);
      bit acc;
      int n;
      acc = 1'b0;
      n   = 0;
      in_valid = 1'b1; in_op = op; a_vec = a; b_vec = b; in_last = last; cur_lit = lit;
      while (!acc && (n < 100)) begin
         @(negedge clk);
         acc = ir[0];
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      cur_lit  = -1;
      if (!acc) chk("send_timeout", 64'd0, 64'd1);
   endtask

   task automatic rand_vec(input logic last);
      in_op   = 2'($urandom_range(0, 3));
      in_last = last;
      for (int i = 0; i < 4; i++) begin
         a_vec[i*16 +: 16] = rnd_lane();
         b_vec[i*16 +: 16] = rnd_lane();
      end
   endtask

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Main stimulus sequence.
   initial begin
      int          acc_cnt;
      int          k;
      int          guard;
      int          emit0;
      logic [63:0] snap;

      rst = 1'b1; in_valid = 1'b0; in_op = 2'd0; in_last = 1'b0;
      a_vec = '0; b_vec = '0; out_ready = 1'b1;
`ifdef EWA_SAT_CNT_EN
      sat_clr = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int g = 0; g < NI; g++) begin
         chk("reset_out_valid", 64'(ov[g]), 64'd0);
         chk("reset_busy", 64'(bz[g]), 64'd0);
         chk("reset_in_ready", 64'(ir[g]), 64'd1);
         chk("reset_y_vec", yw[g], 64'd0);
         chk("reset_out_sat", 64'(sw[g]), 64'd0);
         chk("reset_out_last", 64'(ol[g]), 64'd0);
      end

      // Hand-computed vectors, back to back.
      for (int i = 0; i < 4; i++) send(lit_op[i], lit_a[i], lit_b[i], (i == 3), i);
      idle(6);

      // Backpressure: only STAGES vectors fit while out_ready is low.
      out_ready = 1'b0;
      acc_cnt = 0; k = 0; guard = 0; snap = '0;
      emit0 = n_emit;
      in_valid = 1'b1;
      rand_vec(1'b0);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (ir[0]) begin
            acc_cnt++;
            k++;
         end
         @(posedge clk);
         #1;
         if (ir[0] == 1'b0 && c == 4) snap = yw[0];
         if (k < 5) rand_vec(k == 4);
         else in_valid = 1'b0;
      end
      chk("bp_accepted", 64'(acc_cnt), 64'd3);
      chk("bp_in_ready_low", 64'(ir[0]), 64'd0);
      chk("bp_out_stable", yw[0], snap);
      out_ready = 1'b1;
      while ((k < 5) && (guard < 50)) begin
         @(negedge clk);
         if (ir[0]) k++;
         @(posedge clk);
         #1;
         guard++;
         if (k < 5) rand_vec(k == 4);
         else in_valid = 1'b0;
      end
      in_valid = 1'b0;
      idle(6);
      chk("bp_all_emitted", 64'(n_emit - emit0), 64'd5);

      // Random traffic: steady out_ready first (exact latency), then random stalls.
      for (int c = 0; c < 1500; c++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = (c < 500) ? 1'b1 : ($urandom_range(0, 3) != 0);
         rand_vec($urandom_range(0, 7) == 0);
`ifdef EWA_SAT_CNT_EN
         sat_clr = ($urandom_range(0, 39) == 0);
`endif
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
`ifdef EWA_SAT_CNT_EN
      sat_clr = 1'b0;
`endif
      idle(8);

      // Reset with vectors in flight and the output stalled.
      out_ready = 1'b0;
      send(2'd0, lit_a[0], lit_b[0], 1'b1, -1);
      send(2'd0, lit_a[0], lit_b[0], 1'b1, -1);
      idle(1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("midrst_out_valid", 64'(ov[0]), 64'd0);
      chk("midrst_busy", 64'(bz[0]), 64'd0);
      chk("midrst_in_ready", 64'(ir[0]), 64'd1);
      chk("midrst_y_vec", yw[0], 64'd0);
      chk("midrst_out_last", 64'(ol[0]), 64'd0);
      out_ready = 1'b1;
      idle(5);

`ifdef EWA_SAT_CNT_EN
      // Three saturating transfers on the signed instance, then clear.
      for (int i = 0; i < 3; i++) send(2'd0, 64'h7FFF_7FFF_7FFF_7FFF, 64'h0001_0001_0001_0001, 1'b0, -1);
      idle(5);
      chk("satcnt_signed", 64'(scw[0]), 64'd3);
      chk("satcnt_unsigned", 64'(scw[1]), 64'd0);
      chk("satcnt_wrap", 64'(scw[2]), 64'd0);
      sat_clr = 1'b1;
      @(posedge clk);
      #1;
      sat_clr = 1'b0;
      chk("satcnt_clear", 64'(scw[0]), 64'd0);
`endif

      idle(4);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
